// File: rtl/uart_pkg.sv
// Shared definitions for the fast_uart TX/RX paths.
//   uart_state_e        - frame-level FSM state, common to both directions
//   DATA_BITS           - payload bits per 8N1 frame
//   clocks_per_bit()    - clock cycles per bit for a given clock and line rate
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;

  // Truncating division: the residual rate error is left to the receiver's
  // centre sampling to absorb.
  function automatic int unsigned clocks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that paces one serial bit.
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   load_full  - reload for a full bit period (tick after CLOCKS_PER_BIT clocks)
//   load_half  - reload for half a bit period (tick after CLOCKS_PER_BIT/2 clocks)
//   tick       - high while the count has expired; consumers act on it only in
//                states where they are waiting for the timer
module uart_bit_timer #(
  parameter int unsigned CLOCKS_PER_BIT = 43
) (
  input  logic clk,
  input  logic rst,
  input  logic load_full,
  input  logic load_half,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT + 1);
  // Loads are one less than the period because the expiry cycle itself counts.
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLOCKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_full) begin
      cnt_d = FULL_LOAD;
    end else if (load_half) begin
      cnt_d = HALF_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/fast_uart.sv
// Full-duplex 8N1 UART with a fixed, parameter-derived baud rate.
//   clk             - system clock
//   rst             - asynchronous active-low reset
//   txEnable        - transmit request; accepted only while the transmitter is idle
//   txData          - byte to send, captured on acceptance
//   txBusy          - high from acceptance until the stop bit has completed
//   rxDataAvailable - one-cycle pulse when a correctly framed byte arrives
//   rxData          - last correctly framed byte
//   rx              - serial input, idle high, asynchronous to clk
//   tx              - serial output, idle high
module fast_uart
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 40000000,
  parameter int unsigned BAUD     = 921600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 txEnable,
  input  logic [DATA_BITS-1:0] txData,
  output logic                 txBusy,
  output logic                 rxDataAvailable,
  output logic [DATA_BITS-1:0] rxData,
  input  logic                 rx,
  output logic                 tx
);

  localparam int unsigned CLOCKS_PER_BIT = clocks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0]  LAST_BIT       = 3'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  uart_state_e          tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic                 tx_q, tx_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_load;
  logic                 tx_tick;

  uart_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_tx_timer (
    .clk       (clk),
    .rst       (rst),
    .load_full (tx_load),
    .load_half (1'b0),
    .tick      (tx_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      IDLE: begin
        if (txEnable) begin
          tx_state_d = START;
          tx_shift_d = txData;
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
          tx_load    = 1'b1;
        end
      end
      START: begin
        if (tx_tick) begin
          tx_state_d = DATA;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = '0;
          tx_load    = 1'b1;
        end
      end
      DATA: begin
        if (tx_tick) begin
          tx_load = 1'b1;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = STOP;
            tx_d       = 1'b1;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tx_tick) begin
          tx_state_d = IDLE;
          tx_busy_d  = 1'b0;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign tx     = tx_q;
  assign txBusy = tx_busy_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  // Synchroniser and edge-history flops idle high so reset never fakes a start.
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic                 rx_fall;
  uart_state_e          rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_load_full, rx_load_half;
  logic                 rx_tick;

  uart_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_rx_timer (
    .clk       (clk),
    .rst       (rst),
    .load_full (rx_load_full),
    .load_half (rx_load_half),
    .tick      (rx_tick)
  );

  // Edge-triggered start: a line stuck low after a bad stop bit must rise
  // and fall again before it can open a new frame.
  assign rx_fall = rx_prev_q & ~rx_sync_q;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_shift_d   = rx_shift_q;
    rx_bit_d     = rx_bit_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_load_full = 1'b0;
    rx_load_half = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (rx_fall) begin
          rx_state_d   = START;
          rx_load_half = 1'b1;
        end
      end
      START: begin
        if (rx_tick) begin
          if (rx_sync_q) begin
            rx_state_d = IDLE;  // too short to be a start bit
          end else begin
            rx_state_d   = DATA;
            rx_bit_d     = '0;
            rx_load_full = 1'b1;
          end
        end
      end
      DATA: begin
        if (rx_tick) begin
          rx_shift_d   = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_load_full = 1'b1;
          if (rx_bit_q == LAST_BIT) begin
            rx_state_d = STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (rx_tick) begin
          // Leave at the stop-bit centre so the next start edge is not missed.
          rx_state_d = IDLE;
          if (rx_sync_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rxData          = rx_data_q;
  assign rxDataAvailable = rx_valid_q;

endmodule

// File: tb/tb_fast_uart.sv
// Directed self-checking bench for fast_uart at 40 MHz / 921600 baud (43 clocks/bit).
`timescale 1ns/1ps
module tb_fast_uart;

  localparam int CPB = 43;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       txEnable = 1'b0;
  logic [7:0] txData   = 8'h00;
  logic       rx_line  = 1'b1;
  logic       loopback = 1'b0;
  logic       txBusy;
  logic       rxDataAvailable;
  logic [7:0] rxData;
  logic       rx;
  logic       tx;

  assign rx = loopback ? tx : rx_line;

  fast_uart #(
    .CLK_FREQ (40000000),
    .BAUD     (921600)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .txEnable        (txEnable),
    .txData          (txData),
    .txBusy          (txBusy),
    .rxDataAvailable (rxDataAvailable),
    .rxData          (rxData),
    .rx              (rx),
    .tx              (tx)
  );

  always #12.5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Receive monitor: logs every pulse and flags pulses wider than one clock.
  logic [7:0] rx_log[$];
  int         width_err  = 0;
  logic       avail_prev = 1'b0;

  always @(negedge clk) begin
    if (rxDataAvailable === 1'b1) begin
      rx_log.push_back(rxData);
      if (avail_prev) width_err++;
    end
    avail_prev = (rxDataAvailable === 1'b1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input logic v, input string tag);
    int n = 0;
    while (txBusy !== v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(txBusy), 32'(v));
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop, input int period);
    rx_line = 1'b0;
    cycles(period);
    for (int k = 0; k < 8; k++) begin
      rx_line = b[k];
      cycles(period);
    end
    rx_line = stop;
    cycles(period);
    rx_line = 1'b1;
    cycles(2 * period);
  endtask

  logic [7:0] hello [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
  // 'H' on the wire, index 0 = start bit: 0,0,0,0,1,0,0,1,0,1
  logic [9:0] exp_bits  = 10'b1010010000;

  initial begin
    int         c;
    int         base;
    logic [9:0] got_bits;

    // Reset, with rx toggling underneath.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx_line = ~rx_line;
    end
    rx_line = 1'b1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(txBusy), 32'd0);
    check("rst_avail", 32'(rxDataAvailable), 32'd0);
    check("rst_rxdata", 32'(rxData), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    cycles(20);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_busy", 32'(txBusy), 32'd0);
    check("idle_rxdata", 32'(rxData), 32'h00);
    check("idle_no_rx", 32'(rx_log.size()), 32'd0);

    // Single 'H' frame: bit-centre samples and busy length.
    txData   = 8'h48;
    txEnable = 1'b1;
    @(negedge clk);
    txEnable = 1'b0;
    got_bits = '0;
    c = 0;
    while (txBusy === 1'b1 && c < 1000) begin
      if (c % CPB == CPB / 2 && c / CPB < 10) got_bits[c / CPB] = tx;
      c++;
      @(negedge clk);
    end
    check("tx_busy_len", 32'(c), 32'd430);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx_bit%0d", k), 32'(got_bits[k]), 32'(exp_bits[k]));
    end
    check("tx_idle_after", 32'(tx), 32'd1);

    // Loopback "Hello" with txEnable held across frames.
    cycles(5);
    loopback = 1'b1;
    base = rx_log.size();
    for (int i = 0; i < 5; i++) begin
      txData   = hello[i];
      txEnable = 1'b1;
      wait_busy(1'b1, $sformatf("hello_accept%0d", i));
      wait_busy(1'b0, $sformatf("hello_done%0d", i));
    end
    txEnable = 1'b0;
    cycles(50);
    check("hello_count", 32'(rx_log.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (rx_log.size() > base + i)
        check($sformatf("hello_byte%0d", i), 32'(rx_log[base + i]), 32'(hello[i]));
      else
        check($sformatf("hello_byte%0d", i), 32'hFFFF_FFFF, 32'(hello[i]));
    end
    check("pulse_width", 32'(width_err), 32'd0);
    loopback = 1'b0;

    // Glitch rejection, then a good 0xA5 frame.
    cycles(10);
    base = rx_log.size();
    rx_line = 1'b0;
    cycles(10);
    rx_line = 1'b1;
    cycles(100);
    check("glitch_no_rx", 32'(rx_log.size() - base), 32'd0);
    drive_frame(8'hA5, 1'b1, CPB);
    check("a5_count", 32'(rx_log.size() - base), 32'd1);
    check("a5_data", 32'(rxData), 32'hA5);

    // Framing error on 0x3C, then a good 0x81.
    base = rx_log.size();
    drive_frame(8'h3C, 1'b0, CPB);
    check("frame_err_no_rx", 32'(rx_log.size() - base), 32'd0);
    check("frame_err_keep", 32'(rxData), 32'hA5);
    drive_frame(8'h81, 1'b1, CPB);
    check("81_count", 32'(rx_log.size() - base), 32'd1);
    check("81_data", 32'(rxData), 32'h81);

    // +/-2 % bit periods.
    base = rx_log.size();
    drive_frame(8'h55, 1'b1, 42);
    check("fast_count", 32'(rx_log.size() - base), 32'd1);
    check("fast_data", 32'(rxData), 32'h55);
    rxData_clear_guard: begin
      drive_frame(8'hAA, 1'b1, CPB);  // change rxData so the slow frame must rewrite it
    end
    base = rx_log.size();
    drive_frame(8'h55, 1'b1, 44);
    check("slow_count", 32'(rx_log.size() - base), 32'd1);
    check("slow_data", 32'(rxData), 32'h55);

    // txEnable during a frame is ignored.
    loopback = 1'b1;
    base = rx_log.size();
    txData   = 8'h5A;
    txEnable = 1'b1;
    @(negedge clk);
    txEnable = 1'b0;
    c = 0;
    while (txBusy === 1'b1 && c < 1000) begin
      if (c == 100) begin
        txData   = 8'hFF;
        txEnable = 1'b1;
      end
      if (c == 150) txEnable = 1'b0;
      c++;
      @(negedge clk);
    end
    check("busy_len", 32'(c), 32'd430);
    cycles(30);
    check("busy_no_requeue", 32'(txBusy), 32'd0);
    check("busy_rx_count", 32'(rx_log.size() - base), 32'd1);
    check("busy_rx_data", 32'(rxData), 32'h5A);

    // Reset mid-frame returns tx high at once.
    txData   = 8'h00;
    txEnable = 1'b1;
    @(negedge clk);
    txEnable = 1'b0;
    cycles(60);
    rst = 1'b0;
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(txBusy), 32'd0);
    cycles(2);
    rst = 1'b1;
    cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
